// File: rtl/dpram_pkg.sv
// Package for the data-memory responder: port B state type, byte geometry
// and the out-of-range address test used when DPRAM_RANGE_CHK_EN is defined.
`include "defines.sv"

package dpram_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } b_state_e;

    localparam int BYTE_W = 8;

    // An address is out of range when any bit above the word-index field is set.
    function automatic logic addr_oor(input logic [`ADDR_WIDTH-1:0] addr,
                                      input int                     idx_w);
        return (addr >> (idx_w + 2)) != '0;
    endfunction

endpackage

// File: rtl/defines.sv
// Shared core-wide defines.
//   DATA_WIDTH   : data word width in bits
//   ADDR_WIDTH   : byte address width in bits
//   WRITE_ENABLE : asserted level of a write-enable strobe
//   ZERO         : all-zero data word
//   BE_WIDTH     : byte enables per data word
`ifndef CORE_DEFINES_SV
`define CORE_DEFINES_SV

`define DATA_WIDTH   32
`define ADDR_WIDTH   32
`define WRITE_ENABLE 1'b1
`define ZERO         32'h0000_0000
`define BE_WIDTH     4

`endif

// File: rtl/dpram_array.sv
// Storage array for dpram. Holds the words only, no control.
// Ports:
//   clk_i      : clock
//   a_idx_i    : port A word index (asynchronous read, word write)
//   a_we_i     : port A word write strobe
//   a_wdata_i  : port A write word
//   a_rdata_o  : port A read word, combinational
//   b_idx_i    : port B word index (synchronous read, byte-enable write)
//   b_re_i     : port B read strobe, loads b_rdata_o at the edge
//   b_we_i     : port B write strobe
//   b_be_i     : port B byte enables
//   b_wdata_i  : port B write data
//   b_rdata_o  : port B registered read word (pre-write value)
`include "defines.sv"

module dpram_array
    import dpram_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk_i,
    input  logic [IDX_W-1:0]       a_idx_i,
    input  logic                   a_we_i,
    input  logic [`DATA_WIDTH-1:0] a_wdata_i,
    output logic [`DATA_WIDTH-1:0] a_rdata_o,
    input  logic [IDX_W-1:0]       b_idx_i,
    input  logic                   b_re_i,
    input  logic                   b_we_i,
    input  logic [`BE_WIDTH-1:0]   b_be_i,
    input  logic [`DATA_WIDTH-1:0] b_wdata_i,
    output logic [`DATA_WIDTH-1:0] b_rdata_o
);

    logic [`DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [`DATA_WIDTH-1:0] b_rdata_q;

    assign a_rdata_o = mem_q[a_idx_i];
    assign b_rdata_o = b_rdata_q;

    // Contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem_q[a_idx_i] <= a_wdata_i;
        end else if (b_we_i) begin
            for (int n = 0; n < `BE_WIDTH; n++) begin
                if (b_be_i[n]) begin
                    mem_q[b_idx_i][n*BYTE_W +: BYTE_W] <= b_wdata_i[n*BYTE_W +: BYTE_W];
                end
            end
        end
        if (b_re_i) begin
            b_rdata_q <= mem_q[b_idx_i];
        end
    end

endmodule

// File: rtl/dpram.sv
// Data-memory responder. Port A serves the core MEM stage (combinational
// read, full-word write); port B is a valid/ready byte-masked access port for
// the loader/debug host. Port A always wins: port B is stalled in any cycle
// in which port A writes.
// Optional feature macro: DPRAM_RANGE_CHK_EN (address range checking, err_o).
// Ports:
//   clk_i, rst_ni          : clock, async active-low reset
//   a_ce_i, a_we_i         : port A enable / write enable
//   a_addr_i, a_data_i     : port A byte address / write word
//   a_data_o               : port A read word (0 when not enabled)
//   b_valid_i, b_ready_o   : port B request handshake
//   b_we_i, b_addr_i       : port B write/read select, byte address
//   b_be_i, b_wdata_i      : port B byte enables, write data
//   b_rvalid_o, b_rready_i : port B response handshake
//   b_rdata_o              : port B read data (0 for write responses)
//   err_o                  : sticky range error (DPRAM_RANGE_CHK_EN only)
//
// Port B FSM
//   state   | meaning
//   IDLE    | no request outstanding; may accept when port A is not writing
//   RESP    | response presented, held until b_rready_i
`include "defines.sv"

module dpram
    import dpram_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   a_ce_i,
    input  logic                   a_we_i,
    input  logic [`ADDR_WIDTH-1:0] a_addr_i,
    input  logic [`DATA_WIDTH-1:0] a_data_i,
    output logic [`DATA_WIDTH-1:0] a_data_o,
    input  logic                   b_valid_i,
    output logic                   b_ready_o,
    input  logic                   b_we_i,
    input  logic [`ADDR_WIDTH-1:0] b_addr_i,
    input  logic [`BE_WIDTH-1:0]   b_be_i,
    input  logic [`DATA_WIDTH-1:0] b_wdata_i,
    output logic                   b_rvalid_o,
    input  logic                   b_rready_i,
    output logic [`DATA_WIDTH-1:0] b_rdata_o
`ifdef DPRAM_RANGE_CHK_EN
    ,
    output logic                   err_o
`endif
);

    b_state_e               state_q, state_d;
    logic                   rd_sel_q, rd_sel_d;

    logic [IDX_W-1:0]       a_idx, b_idx;
    logic                   a_oor, b_oor;
    logic                   a_wr, a_wr_ok;
    logic                   b_accept;
    logic                   b_arr_we, b_arr_re;
    logic [`DATA_WIDTH-1:0] arr_a_rdata, arr_b_rdata;
    logic                   unused_addr_bits;

    assign a_idx = a_addr_i[IDX_W+1:2];
    assign b_idx = b_addr_i[IDX_W+1:2];

    // Byte-offset bits (and, without range checking, upper bits) are ignored.
    assign unused_addr_bits = ^{a_addr_i, b_addr_i};

`ifdef DPRAM_RANGE_CHK_EN
    assign a_oor = addr_oor(a_addr_i, IDX_W);
    assign b_oor = addr_oor(b_addr_i, IDX_W);
`else
    assign a_oor = 1'b0;
    assign b_oor = 1'b0;
`endif

    assign a_wr    = a_ce_i & (a_we_i == `WRITE_ENABLE);
    assign a_wr_ok = a_wr & ~a_oor;

    assign a_data_o = (a_ce_i & ~a_oor) ? arr_a_rdata : `ZERO;

    // Stall on any port A write, regardless of address, so the array never
    // sees two writers in one cycle.
    assign b_ready_o = rst_ni & (state_q == ST_IDLE) & ~a_wr;
    assign b_accept  = b_valid_i & b_ready_o;

    always_comb begin
        state_d  = state_q;
        rd_sel_d = rd_sel_q;
        b_arr_we = 1'b0;
        b_arr_re = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (b_accept) begin
                    state_d = ST_RESP;
                    if (b_we_i) begin
                        b_arr_we = ~b_oor;
                        rd_sel_d = 1'b0;
                    end else begin
                        b_arr_re = ~b_oor;
                        rd_sel_d = ~b_oor;
                    end
                end
            end
            ST_RESP: begin
                if (b_rready_i) begin
                    state_d  = ST_IDLE;
                    rd_sel_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rd_sel_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            rd_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    assign b_rvalid_o = (state_q == ST_RESP);
    // The array's B read register only loads on an accepted read, so it is
    // stable for the whole response; writes and out-of-range reads show 0.
    assign b_rdata_o  = rd_sel_q ? arr_b_rdata : `ZERO;

`ifdef DPRAM_RANGE_CHK_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if ((a_ce_i & a_oor) | (b_accept & b_oor)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

    dpram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i     (clk_i),
        .a_idx_i   (a_idx),
        .a_we_i    (a_wr_ok),
        .a_wdata_i (a_data_i),
        .a_rdata_o (arr_a_rdata),
        .b_idx_i   (b_idx),
        .b_re_i    (b_arr_re),
        .b_we_i    (b_arr_we),
        .b_be_i    (b_be_i),
        .b_wdata_i (b_wdata_i),
        .b_rdata_o (arr_b_rdata)
    );

endmodule

// File: tb/tb_dpram.sv
// Self-checking bench for dpram: directed scenarios with literal expectations
// followed by randomized traffic against a behavioural memory model.
module tb_dpram;

    localparam int DEPTH = 1024;
    localparam int IDX_W = 10;
`ifdef DPRAM_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_ce = 1'b0, a_we = 1'b0;
    logic [31:0] a_addr = '0, a_data = '0;
    logic [31:0] a_rdata;
    logic        b_valid = 1'b0, b_we = 1'b0, b_rready = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic [3:0]  b_be = '0;
    logic        b_ready_o, b_rvalid_o;
    logic [31:0] b_rdata_o;
`ifdef DPRAM_RANGE_CHK_EN
    logic        err_o;
`endif

    always #5 clk = ~clk;

    dpram #(.DEPTH_WORDS(DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .a_ce_i     (a_ce),
        .a_we_i     (a_we),
        .a_addr_i   (a_addr),
        .a_data_i   (a_data),
        .a_data_o   (a_rdata),
        .b_valid_i  (b_valid),
        .b_ready_o  (b_ready_o),
        .b_we_i     (b_we),
        .b_addr_i   (b_addr),
        .b_be_i     (b_be),
        .b_wdata_i  (b_wdata),
        .b_rvalid_o (b_rvalid_o),
        .b_rready_i (b_rready),
        .b_rdata_o  (b_rdata_o)
`ifdef DPRAM_RANGE_CHK_EN
        ,
        .err_o      (err_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [31:0] m_resp [$];
    bit          m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[IDX_W+1:2]);
    endfunction

    function automatic bit oor(input logic [31:0] a);
        return CHK && ((a >> (IDX_W + 2)) != 0);
    endfunction

    // Reference model: memory array plus a queue holding at most one response.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_resp.delete();
            m_err = 1'b0;
        end else begin
            bit busy;
            busy = (m_resp.size() != 0);
            if (busy && b_rready) void'(m_resp.pop_front());
            if (!busy && !(a_ce && a_we) && b_valid) begin
                if (oor(b_addr)) begin
                    m_err = 1'b1;
                    m_resp.push_back(32'h0);
                end else if (b_we) begin
                    for (int n = 0; n < 4; n++)
                        if (b_be[n]) m_mem[widx(b_addr)][8*n +: 8] = b_wdata[8*n +: 8];
                    m_resp.push_back(32'h0);
                end else begin
                    m_resp.push_back(m_mem[widx(b_addr)]);
                end
            end
            if (a_ce) begin
                if (oor(a_addr)) m_err = 1'b1;
                else if (a_we) begin
                    m_mem[widx(a_addr)]   = a_data;
                    m_known[widx(a_addr)] = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk1("b_ready", b_ready_o, rst_n && (m_resp.size() == 0) && !(a_ce && a_we));
        chk1("b_rvalid", b_rvalid_o, m_resp.size() != 0);
        chk("b_rdata", b_rdata_o, (m_resp.size() != 0) ? m_resp[0] : 32'h0);
        if (!a_ce || oor(a_addr)) chk("a_data_off", a_rdata, 32'h0);
        else if (m_known[widx(a_addr)]) chk("a_data", a_rdata, m_mem[widx(a_addr)]);
`ifdef DPRAM_RANGE_CHK_EN
        chk1("err", err_o, m_err);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_xact(input bit we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd);
        bit ok;
        ok = 1'b0;
        rd = '0;
        b_valid = 1'b1; b_we = we; b_addr = addr; b_be = be; b_wdata = wd; b_rready = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (b_ready_o) ok = 1'b1;
        end
        chk1("b_accept_in_time", ok, 1'b1);
        tick();
        b_valid = 1'b0;
        b_rready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (b_rvalid_o) begin
                ok = 1'b1;
                rd = b_rdata_o;
            end
        end
        chk1("b_resp_in_time", ok, 1'b1);
        tick();
        b_rready = 1'b0;
    endtask

    function automatic logic [31:0] raddr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] first;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_rvalid", b_rvalid_o, 1'b0);
        chk1("rst_ready", b_ready_o, 1'b0);
        chk("rst_rdata", b_rdata_o, 32'h0);
        tick();
        rst_n = 1'b1;

        // Preload every word so the model knows the whole array
        a_ce = 1'b1; a_we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            a_addr = 32'(i) * 4;
            a_data = 32'hC0DE_0000 | 32'(i);
            tick();
        end
        a_we = 1'b0; a_ce = 1'b0;

        // Port A write then read; disabled read gives 0
        a_ce = 1'b1; a_we = 1'b1; a_addr = 32'h10; a_data = 32'hDEADBEEF;
        tick();
        a_we = 1'b0;
        @(negedge clk);
        chk("a_rd_10", a_rdata, 32'hDEADBEEF);
        tick();
        a_ce = 1'b0;
        @(negedge clk);
        chk("a_rd_ce0", a_rdata, 32'h0);

        // Byte-masked B write over a preloaded word
        tick();
        a_ce = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_data = 32'hAABBCCDD;
        tick();
        a_ce = 1'b0; a_we = 1'b0;
        b_xact(1'b1, 32'h20, 4'b0101, 32'h11223344, rd);
        chk("b_wr_resp_zero", rd, 32'h0);
        b_xact(1'b0, 32'h20, 4'b0000, 32'h0, rd);
        chk("b_rd_merged", rd, 32'hAA22CC44);

        // Port A writes stall port B for three cycles
        b_valid = 1'b1; b_we = 1'b0; b_addr = 32'h40; b_rready = 1'b1;
        a_ce = 1'b1; a_we = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_addr = 32'h100 + 32'(k) * 4;
            a_data = 32'h5000 + 32'(k);
            @(negedge clk);
            chk1("stall_ready", b_ready_o, 1'b0);
            tick();
        end
        a_ce = 1'b0; a_we = 1'b0;
        @(negedge clk);
        chk1("ready_4th", b_ready_o, 1'b1);
        tick();
        b_valid = 1'b0;
        @(negedge clk);
        chk1("resp_4th_valid", b_rvalid_o, 1'b1);
        chk("resp_4th_data", b_rdata_o, 32'hC0DE0010);
        tick();
        b_rready = 1'b0;

        // Response held while b_rready_i is low
        b_valid = 1'b1; b_we = 1'b0; b_addr = 32'h30;
        @(negedge clk);
        chk1("hold_accept", b_ready_o, 1'b1);
        tick();
        b_valid = 1'b0;
        @(negedge clk);
        first = b_rdata_o;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk1("hold_rvalid", b_rvalid_o, 1'b1);
            chk("hold_rdata", b_rdata_o, 32'hC0DE000C);
            chk("hold_stable", b_rdata_o, first);
            chk1("hold_ready", b_ready_o, 1'b0);
            tick();
        end
        b_rready = 1'b1;
        tick();
        b_rready = 1'b0;

        // Reset while a response is pending
        b_valid = 1'b1; b_we = 1'b0; b_addr = 32'h50;
        tick();
        b_valid = 1'b0;
        @(negedge clk);
        chk1("pre_rst_rvalid", b_rvalid_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("rst_async_rvalid", b_rvalid_o, 1'b0);
        chk1("rst_async_ready", b_ready_o, 1'b0);
        a_ce = 1'b1; a_we = 1'b0; a_addr = 32'h10;
        #1;
        chk("rst_a_read", a_rdata, 32'hDEADBEEF);
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_read", a_rdata, 32'hDEADBEEF);
        chk1("post_rst_rvalid", b_rvalid_o, 1'b0);
        tick();

        // Write beyond the array
        a_ce = 1'b1; a_we = 1'b1; a_addr = 32'h1000; a_data = 32'h12345678;
        tick();
        a_we = 1'b0; a_addr = 32'h0;
        @(negedge clk);
`ifdef DPRAM_RANGE_CHK_EN
        chk("oor_word0_unchanged", a_rdata, 32'hC0DE0000);
        chk1("oor_err", err_o, 1'b1);
`else
        chk("wrap_word0", a_rdata, 32'h12345678);
`endif
        tick();
        a_ce = 1'b0;

        // Write with no byte enables still responds, changes nothing
        b_xact(1'b1, 32'h60, 4'b0000, 32'hFFFFFFFF, rd);
        chk("be0_resp", rd, 32'h0);
        a_ce = 1'b1; a_addr = 32'h60;
        @(negedge clk);
        chk("be0_unchanged", a_rdata, 32'hC0DE0018);
        tick();
        a_ce = 1'b0;

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            a_ce     = ($urandom_range(0, 1) == 1);
            a_we     = ($urandom_range(0, 1) == 1);
            a_addr   = raddr();
            a_data   = $urandom;
            b_valid  = ($urandom_range(0, 9) < 6);
            b_we     = ($urandom_range(0, 1) == 1);
            b_addr   = raddr();
            b_be     = 4'($urandom_range(0, 15));
            b_wdata  = $urandom;
            b_rready = ($urandom_range(0, 9) < 7);
            tick();
        end
        a_ce = 1'b0; a_we = 1'b0; b_valid = 1'b0; b_rready = 1'b1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
